// File: rtl/ssd_scan_ctrl.sv
// Four-digit seven-segment scan controller: double-buffered BCD value committed at frame
// boundaries, digit rotation with a fixed dwell time and optional leading-zero blanking.
module ssd_scan_ctrl #(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] value,
   input  logic        lz_blank,
   output logic [3:0]  ssd_in,
   output logic [3:0]  ssd_en,
   output logic        pending,
   output logic        load_ack,
   output logic        frame_tick
);

   localparam int unsigned     PC_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(SCAN_DIV - 1);

   logic [PC_W-1:0] pc_q, pc_d;
   logic [1:0]      idx_q, idx_d;
   logic [15:0]     disp_q, disp_d;
   logic [15:0]     shad_q, shad_d;
   logic            pend_q, pend_d;
   logic            ack_q, ack_d;
   logic            tick_q, tick_d;
   logic            lz_q;
   logic [3:0]      ssd_in_q, ssd_in_d;
   logic [3:0]      ssd_en_q, ssd_en_d;
   logic            step_s;
   logic            bnd_s;

   // Digit k is dark when blanking is on and nibbles k..3 are all zero; digit 0 always shows.
   function automatic logic digit_blank(input logic [15:0] d, input logic [1:0] k, input logic lz);
      logic b;
      case (k)
         2'd1:    b = lz && (d[15:4] == 12'h000);
         2'd2:    b = lz && (d[15:8] == 8'h00);
         2'd3:    b = lz && (d[15:12] == 4'h0);
         default: b = 1'b0;
      endcase
      return b;
   endfunction

   function automatic logic [3:0] nibble(input logic [15:0] d, input logic [1:0] k);
      logic [3:0] n;
      case (k)
         2'd0:    n = d[3:0];
         2'd1:    n = d[7:4];
         2'd2:    n = d[11:8];
         2'd3:    n = d[15:12];
         default: n = 4'h0;
      endcase
      return n;
   endfunction

   function automatic logic [3:0] enable_mask(input logic [1:0] k);
      logic [3:0] m;
      case (k)
         2'd0:    m = 4'b1110;
         2'd1:    m = 4'b1101;
         2'd2:    m = 4'b1011;
         2'd3:    m = 4'b0111;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   assign step_s = (pc_q == PC_LAST);
   assign bnd_s  = step_s && (idx_q == 2'd3);

   // Next-state: prescaler, digit index, shadow/commit handshake and output decode.
   always_comb begin
      pc_d   = step_s ? '0 : pc_q + PC_W'(1);
      idx_d  = step_s ? idx_q + 2'd1 : idx_q;
      disp_d = disp_q;
      shad_d = shad_q;
      pend_d = pend_q;
      ack_d  = 1'b0;
      tick_d = bnd_s;
      if (bnd_s) begin
         // A load on the boundary itself bypasses the shadow so it is never a frame late.
         if (load) begin
            disp_d = value;
            pend_d = 1'b0;
            ack_d  = 1'b1;
         end else if (pend_q) begin
            disp_d = shad_q;
            pend_d = 1'b0;
            ack_d  = 1'b1;
         end else begin
            disp_d = disp_q;
         end
      end else if (load) begin
         shad_d = value;
         pend_d = 1'b1;
      end else begin
         shad_d = shad_q;
      end
      ssd_in_d = nibble(disp_d, idx_d);
      // Blanking uses the already-registered lz copy, giving the two-edge response to lz_blank.
      if (digit_blank(disp_d, idx_d, lz_q)) begin
         ssd_en_d = 4'b1111;
      end else begin
         ssd_en_d = enable_mask(idx_d);
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= '0;
         idx_q    <= 2'd0;
         disp_q   <= 16'h0000;
         shad_q   <= 16'h0000;
         pend_q   <= 1'b0;
         ack_q    <= 1'b0;
         tick_q   <= 1'b0;
         lz_q     <= 1'b0;
         ssd_in_q <= 4'h0;
         ssd_en_q <= 4'b1110;
      end else begin
         pc_q     <= pc_d;
         idx_q    <= idx_d;
         disp_q   <= disp_d;
         shad_q   <= shad_d;
         pend_q   <= pend_d;
         ack_q    <= ack_d;
         tick_q   <= tick_d;
         lz_q     <= lz_blank;
         ssd_in_q <= ssd_in_d;
         ssd_en_q <= ssd_en_d;
      end
   end

   assign ssd_in     = ssd_in_q;
   assign ssd_en     = ssd_en_q;
   assign pending    = pend_q;
   assign load_ack   = ack_q;
   assign frame_tick = tick_q;

endmodule
